// File: rtl/bdemux1_4_buf_pkg.sv
// Shared constants for the buffered 1-to-4 demultiplexer.
// Holds channel count, select width, default lane width/depth, counter width.
package bdemux1_4_buf_pkg;

  localparam int NCH       = 4;
  localparam int SEL_W     = 2;
  localparam int W_DEF     = 2;
  localparam int DEPTH_DEF = 2;
  localparam int CNT_W     = 8;

  function automatic logic [NCH-1:0] sel_onehot(
    input logic [SEL_W-1:0] sel
  );
    logic [NCH-1:0] oh;
    oh = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/bdemux1_4_buf_bfifo_ch.sv
// Single-channel first-word-fall-through FIFO, DEPTH entries.
// Ports: clk, rst_n, push, pop, wdata, rdata (head), full, empty.
module bfifo_ch #(
  parameter int W     = 2,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + PW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + PW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/bdemux1_4_buf.sv
// Buffered 1-to-4 demultiplexer: routes words to one of four FWFT FIFOs.
// Ports: clk, rst_n, in_data/in_sel/in_valid/in_ready, out_data/out_valid/out_ready, xfer_cnt.
module bdemux1_4_buf
  import bdemux1_4_buf_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     in_data,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [NCH*W-1:0] out_data,
  output logic [NCH-1:0]   out_valid,
  input  logic [NCH-1:0]   out_ready,
  output logic [CNT_W-1:0] xfer_cnt
);

  logic [NCH-1:0] full;
  logic [NCH-1:0] empty;
  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;
  logic           acc;

  // Readiness looks only at the selected channel's own fullness.
  assign in_ready  = ~full[in_sel];
  assign acc       = in_valid & in_ready;
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;

  always_comb begin
    push = '0;
    if (acc) begin
      push = sel_onehot(in_sel);
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    bfifo_ch #(
      .W     (W),
      .DEPTH (DEPTH)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[k]),
      .pop   (pop[k]),
      .wdata (in_data),
      .rdata (out_data[k*W +: W]),
      .full  (full[k]),
      .empty (empty[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (acc) begin
      xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bdemux1_4_buf.sv
// Directed self-checking bench for bdemux1_4_buf (W=2, DEPTH=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bdemux1_4_buf;

  logic       clk;
  logic       rst_n;
  logic [1:0] in_data;
  logic [1:0] in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] xfer_cnt;

  int checks;
  int errors;

  bdemux1_4_buf #(
    .W     (2),
    .DEPTH (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push1(input logic [1:0] sel, input logic [1:0] d);
    in_sel   = sel;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [1:0] w [6];
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    in_valid  = 1'b0;
    out_ready = '0;
    w = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};

    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_cnt", 32'(xfer_cnt), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'h1);

    // single word to channel 2
    push1(2'd2, 2'b10);
    chk("c2_valid", 32'(out_valid), 32'h4);
    chk("c2_data", 32'(out_data[5:4]), 32'h2);
    chk("c2_cnt", 32'(xfer_cnt), 32'h1);
    out_ready = 4'b0100;
    @(negedge clk);
    out_ready = 4'b0000;
    chk("c2_pop", 32'(out_valid), 32'h0);

    // fill channel 1, channel 0 still open
    push1(2'd1, 2'b01);
    push1(2'd1, 2'b11);
    in_sel = 2'd1;
    #1 chk("c1_full_rdy", 32'(in_ready), 32'h0);
    in_sel = 2'd0;
    #1 chk("c0_open_rdy", 32'(in_ready), 32'h1);
    @(negedge clk);
    push1(2'd0, 2'b10);
    chk("c01_valid", 32'(out_valid), 32'h3);
    chk("c01_head", 32'(out_data[3:0]), 32'h6);
    chk("c01_cnt", 32'(xfer_cnt), 32'h4);
    out_ready = 4'b0011;
    @(negedge clk);
    chk("c1_next", 32'(out_data[3:2]), 32'h3);
    chk("c1_valid", 32'(out_valid), 32'h2);
    out_ready = 4'b0010;
    @(negedge clk);
    out_ready = 4'b0000;
    chk("c1_drain", 32'(out_valid), 32'h0);

    // full channel 3: pop but no push
    push1(2'd3, 2'b01);
    push1(2'd3, 2'b10);
    in_sel = 2'd3;
    #1 chk("c3_full", 32'(in_ready), 32'h0);
    in_data   = 2'b11;
    in_valid  = 1'b1;
    out_ready = 4'b1000;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    chk("c3_rdy_back", 32'(in_ready), 32'h1);
    chk("c3_head", 32'(out_data[7:6]), 32'h2);
    chk("c3_cnt", 32'(xfer_cnt), 32'h6);
    out_ready = 4'b1000;
    @(negedge clk);
    out_ready = 4'b0000;
    chk("c3_drain", 32'(out_valid), 32'h0);

    // push+pop on channel 0 with pointer wrap
    push1(2'd0, w[0]);
    for (int i = 1; i < 6; i++) begin
      chk("c0_stream_v", 32'(out_valid), 32'h1);
      chk("c0_stream_d", 32'(out_data[1:0]), 32'(w[i-1]));
      in_sel    = 2'd0;
      in_data   = w[i];
      in_valid  = 1'b1;
      out_ready = 4'b0001;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    in_sel    = 2'd0;
    #1 chk("c0_occ1_rdy", 32'(in_ready), 32'h1);
    chk("c0_last", 32'(out_data[1:0]), 32'(w[5]));
    out_ready = 4'b0001;
    @(negedge clk);
    chk("c0_empty", 32'(out_valid), 32'h0);

    // out_ready with nothing buffered
    out_ready = 4'b1111;
    @(negedge clk);
    out_ready = 4'b0000;
    chk("idle_pop_v", 32'(out_valid), 32'h0);
    chk("idle_cnt", 32'(xfer_cnt), 32'd12);

    // async reset discards buffered words
    push1(2'd0, 2'b01);
    push1(2'd1, 2'b10);
    push1(2'd2, 2'b11);
    chk("pre_rst_v", 32'(out_valid), 32'h7);
    #2 rst_n = 1'b0;
    #1 chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_data", 32'(out_data), 32'h0);
    chk("arst_cnt", 32'(xfer_cnt), 32'h0);
    in_sel   = 2'd3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_no_xfer", 32'(xfer_cnt), 32'h0);
    chk("rst_no_push", 32'(out_valid), 32'h0);
    rst_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1 chk("post_rst_rdy", 32'(in_ready), 32'h1);
    end
    @(negedge clk);

    // 257 accepted words wrap the counter
    out_ready = 4'b1111;
    for (int i = 0; i < 257; i++) begin
      if (i == 256) chk("cnt_wrap0", 32'(xfer_cnt), 32'h0);
      in_sel   = 2'(i % 4);
      in_data  = 2'(i);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    chk("cnt_257", 32'(xfer_cnt), 32'h1);
    @(negedge clk);
    out_ready = 4'b0000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
